// File: rtl/mem_bus_pkg.sv
// Shared definitions for the serial memory slave port: default widths,
// bit-counter width and the transaction state encoding.
package mem_bus_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int CNT_WIDTH      = $clog2(DEF_ADDR_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    WRITE,
    RREQ,
    RWAIT,
    RDATA,
    DONE
  } state_t;

endpackage

// File: rtl/mem_slave_port_if.sv
// Serial bus-master signals plus the RAM-side signals of the memory slave port.
interface mem_slave_port_if
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  s_start;
  logic                  s_rw;
  logic                  s_din;
  logic                  s_dout;
  logic                  s_dout_valid;
  logic                  s_busy;
  logic                  s_done;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_wrt_en;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  s_start, s_rw, s_din, mem_rdata,
    output s_dout, s_dout_valid, s_busy, s_done, mem_addr, mem_wdata, mem_wrt_en
  );

  modport master (
    output s_start, s_rw, s_din, mem_rdata,
    input  s_dout, s_dout_valid, s_busy, s_done, mem_addr, mem_wdata, mem_wrt_en
  );

endinterface

// File: rtl/bit_counter.sv
// Serial bit counter: synchronous clear, count enable, and a flag raised
// when the count reaches the caller-supplied last index. It never wraps.
module bit_counter
  import mem_bus_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] last,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  assign tc = (count == last);

  // Holding at the terminal value keeps the counter from wrapping in a state.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_slave_port.sv
// Serial-to-RAM slave port: receives an LSB-first address (and write data)
// from a bus master, performs one RAM access and streams read data back.
module mem_slave_port
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  mem_slave_port_if.slave  bus
);

  localparam int CNT_W = $clog2(ADDR_WIDTH + 1);

  state_t                state_q;
  state_t                state_next;
  logic                  rw_q;
  logic [ADDR_WIDTH-2:0] addr_sr;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rd_sr;

  logic                  cnt_clear;
  logic                  cnt_en;
  logic                  cnt_tc;
  logic [CNT_W-1:0]      cnt_last;

  logic                  busy;
  logic                  done;
  logic                  wrt_en;
  logic                  dout_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next = state_q;
    cnt_en     = 1'b0;
    cnt_last   = CNT_W'(DATA_WIDTH - 1);
    busy       = 1'b1;
    done       = 1'b0;
    wrt_en     = 1'b0;
    dout_valid = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (bus.s_start) state_next = ADDR;
      end
      ADDR: begin
        cnt_en   = 1'b1;
        cnt_last = CNT_W'(ADDR_WIDTH - 1);
        if (cnt_tc) state_next = rw_q ? WDATA : RREQ;
      end
      WDATA: begin
        cnt_en = 1'b1;
        if (cnt_tc) state_next = WRITE;
      end
      WRITE: begin
        wrt_en     = 1'b1;
        state_next = DONE;
      end
      RREQ:  state_next = RWAIT;
      RWAIT: state_next = RDATA;
      RDATA: begin
        cnt_en     = 1'b1;
        dout_valid = 1'b1;
        if (cnt_tc) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Every state change restarts the bit count from zero.
  assign cnt_clear = (state_next != state_q);

  bit_counter #(
    .WIDTH (CNT_W)
  ) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .last   (cnt_last),
    .tc     (cnt_tc)
  );

  // Shift registers fill LSB first; the address is only published on ADDR exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rw_q       <= 1'b0;
      addr_sr    <= '0;
      mem_addr_q <= '0;
      wdata_q    <= '0;
      rd_sr      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.s_start) rw_q <= bus.s_rw;
        end
        ADDR: begin
          addr_sr <= {bus.s_din, addr_sr[ADDR_WIDTH-2:1]};
          if (cnt_tc) mem_addr_q <= {bus.s_din, addr_sr};
        end
        WDATA: wdata_q <= {bus.s_din, wdata_q[DATA_WIDTH-1:1]};
        RWAIT: rd_sr   <= bus.mem_rdata;
        RDATA: rd_sr   <= {1'b0, rd_sr[DATA_WIDTH-1:1]};
        default: ;
      endcase
    end
  end

  // A reset landing on the WRITE cycle must not reach the RAM.
  assign bus.mem_wrt_en   = wrt_en & ~rst;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.s_busy       = busy;
  assign bus.s_done       = done;
  assign bus.s_dout_valid = dout_valid;
  assign bus.s_dout       = dout_valid & rd_sr[0];

endmodule

// File: tb/tb_mem_slave_port.sv
// Bench for mem_slave_port: RAM model, transaction-level reference model
// checked every cycle, plus directed transactions with literal expectations.
module tb_mem_slave_port;

  localparam int AW      = 12;
  localparam int DW      = 8;
  localparam int DEPTH   = 1 << AW;
  localparam int WR_LAST = AW + DW + 2;
  localparam int RD_LAST = AW + DW + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  mem_slave_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_slave_port #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int a);
    int v;
    v = a * 7 + 17;
    if (a == 'h0A5) return 8'hC3;
    return v[DW-1:0];
  endfunction

  // RAM seen by the DUT: registered read, write on mem_wrt_en.
  logic [DW-1:0] ram [0:DEPTH-1];
  bit            ram_loaded = 1'b0;

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_val(i);
      ram_loaded <= 1'b1;
    end else if (bus.mem_wrt_en) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // Reference model: tracks the transaction by cycle offset from its start.
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  bit            ref_loaded = 1'b0;
  bit            act = 1'b0;
  int            cyc = 0;
  bit            m_rw = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] m_rd = '0;

  always @(posedge clk) begin
    if (!ref_loaded) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] <= init_val(i);
      ref_loaded <= 1'b1;
    end
    if (rst) begin
      act      <= 1'b0;
      exp_addr <= '0;
    end else if (!act) begin
      if (bus.s_start) begin
        act  <= 1'b1;
        cyc  <= 1;
        m_rw <= bus.s_rw;
      end
    end else begin
      if (cyc <= AW) m_addr[cyc-1] <= bus.s_din;
      if (cyc == AW) begin
        exp_addr <= {bus.s_din, m_addr[AW-2:0]};
        m_rd     <= ref_mem[{bus.s_din, m_addr[AW-2:0]}];
      end
      if (m_rw && cyc > AW && cyc <= AW + DW) m_data[cyc-AW-1] <= bus.s_din;
      if (m_rw && cyc == AW + DW + 1) ref_mem[exp_addr] <= m_data;
      if (cyc == (m_rw ? WR_LAST : RD_LAST)) act <= 1'b0;
      cyc <= cyc + 1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin : compare
    bit   e_wr;
    bit   e_dv;
    bit   e_done;
    logic e_dout;
    if (chk_en) begin
      e_wr   = act && m_rw && cyc == AW + DW + 1 && !rst;
      e_dv   = act && !m_rw && cyc >= AW + 3 && cyc <= AW + DW + 2;
      e_done = act && cyc == (m_rw ? WR_LAST : RD_LAST);
      e_dout = 1'b0;
      if (e_dv) e_dout = m_rd[cyc-AW-3];
      checkOutput("s_busy", int'(bus.s_busy), int'(act));
      checkOutput("s_done", int'(bus.s_done), int'(e_done));
      checkOutput("s_dout_valid", int'(bus.s_dout_valid), int'(e_dv));
      checkOutput("s_dout", int'(bus.s_dout), int'(e_dout));
      checkOutput("mem_wrt_en", int'(bus.mem_wrt_en), int'(e_wr));
      checkOutput("mem_addr", int'(bus.mem_addr), int'(exp_addr));
      if (e_wr) checkOutput("mem_wdata", int'(bus.mem_wdata), int'(m_data));
    end
  end

  // Per-transaction observations filled by applyStimulus.
  int            t_done;
  int            t_wr_cnt;
  int            t_wr_cyc;
  int            t_nbits;
  logic [AW-1:0] t_wr_addr;
  logic [DW-1:0] t_wr_data;
  logic [DW-1:0] t_rbyte;
  int            t_post_busy;
  int            t_post_addr;
  int            t_post_wdata;

  task automatic applyStimulus(input bit rw, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input int rst_at,
                               input int start_at);
    t_done = -1; t_wr_cnt = 0; t_wr_cyc = -1; t_nbits = 0;
    t_wr_addr = '0; t_wr_data = '0; t_rbyte = '0;
    t_post_busy = -1; t_post_addr = -1; t_post_wdata = -1;
    @(negedge clk);
    bus.s_start = 1'b1;
    bus.s_rw    = rw;
    bus.s_din   = 1'b1;
    for (int k = 1; k <= AW + DW + 10 && t_done < 0; k++) begin
      @(negedge clk);
      bus.s_start = (k == start_at);
      bus.s_rw    = (k == start_at);
      rst         = (k == rst_at);
      if (k <= AW) bus.s_din = addr[k-1];
      else if (rw && k <= AW + DW) bus.s_din = data[k-AW-1];
      else bus.s_din = (k % 3 == 0);
      if (k == rst_at + 1) begin
        t_post_busy  = int'(bus.s_busy);
        t_post_addr  = int'(bus.mem_addr);
        t_post_wdata = int'(bus.mem_wdata);
      end
      if (bus.mem_wrt_en) begin
        t_wr_cnt++;
        t_wr_cyc  = k;
        t_wr_addr = bus.mem_addr;
        t_wr_data = bus.mem_wdata;
      end
      if (bus.s_dout_valid) begin
        if (t_nbits < DW) t_rbyte[t_nbits] = bus.s_dout;
        t_nbits++;
      end
      if (bus.s_done) t_done = k;
    end
    bus.s_start = 1'b0;
    bus.s_rw    = 1'b0;
    bus.s_din   = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic readExpect(input string name, input logic [AW-1:0] addr, input int value);
    applyStimulus(1'b0, addr, '0, -1, -1);
    checkOutput({name, "_data"}, int'(t_rbyte), value);
    checkOutput({name, "_done_cyc"}, t_done, RD_LAST);
    checkOutput({name, "_wr_cnt"}, t_wr_cnt, 0);
  endtask

  task automatic writeExpect(input string name, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    applyStimulus(1'b1, addr, data, -1, -1);
    checkOutput({name, "_done_cyc"}, t_done, WR_LAST);
    checkOutput({name, "_wr_cnt"}, t_wr_cnt, 1);
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int diffs;
    bus.s_start = 1'b0;
    bus.s_rw    = 1'b0;
    bus.s_din   = 1'b0;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    checkOutput("reset_busy", int'(bus.s_busy), 0);
    checkOutput("reset_done", int'(bus.s_done), 0);
    checkOutput("reset_mem_addr", int'(bus.mem_addr), 0);
    checkOutput("reset_mem_wdata", int'(bus.mem_wdata), 0);
    rst = 1'b0;

    $display("[TB] read of preloaded 0x0A5");
    applyStimulus(1'b0, 12'h0A5, 8'h00, -1, -1);
    checkOutput("rd_a5_data", int'(t_rbyte), 'hC3);
    checkOutput("rd_a5_nbits", t_nbits, 8);
    checkOutput("rd_a5_done_cyc", t_done, 23);
    checkOutput("rd_a5_wr_cnt", t_wr_cnt, 0);

    $display("[TB] write 0x3C to 0x0A5");
    applyStimulus(1'b1, 12'h0A5, 8'h3C, -1, -1);
    checkOutput("wr_a5_done_cyc", t_done, 22);
    checkOutput("wr_a5_wr_cyc", t_wr_cyc, 21);
    checkOutput("wr_a5_wr_cnt", t_wr_cnt, 1);
    checkOutput("wr_a5_addr", int'(t_wr_addr), 'h0A5);
    checkOutput("wr_a5_data", int'(t_wr_data), 'h3C);

    $display("[TB] read with stray start at cycle 5");
    applyStimulus(1'b0, 12'h0A5, 8'h00, -1, 5);
    checkOutput("stray_start_data", int'(t_rbyte), 'h3C);
    checkOutput("stray_start_done_cyc", t_done, 23);
    writeExpect("wr_after_done", 12'h0A6, 8'h81);
    readExpect("rd_a6", 12'h0A6, 'h81);

    $display("[TB] boundary addresses");
    writeExpect("wr_000", 12'h000, 8'h00);
    writeExpect("wr_fff", 12'hFFF, 8'hFF);
    readExpect("rd_000", 12'h000, 'h00);
    readExpect("rd_fff", 12'hFFF, 'hFF);
    readExpect("rd_001", 12'h001, 'h18);
    readExpect("rd_ffe", 12'hFFE, 'h03);

    $display("[TB] reset at cycle 18 of a write");
    applyStimulus(1'b1, 12'h123, 8'h5A, 18, -1);
    checkOutput("abort_done", t_done, -1);
    checkOutput("abort_wr_cnt", t_wr_cnt, 0);
    checkOutput("abort_busy", t_post_busy, 0);
    checkOutput("abort_mem_addr", t_post_addr, 0);
    checkOutput("abort_mem_wdata", t_post_wdata, 0);
    readExpect("rd_123", 12'h123, 'h06);

    $display("[TB] reset and start in the same cycle");
    @(negedge clk);
    rst         = 1'b1;
    bus.s_start = 1'b1;
    bus.s_rw    = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    bus.s_start = 1'b0;
    bus.s_rw    = 1'b0;
    checkOutput("rst_prio_busy", int'(bus.s_busy), 0);
    repeat (3) @(negedge clk);

    diffs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ram[i] !== ref_mem[i]) diffs++;
    end
    checkOutput("ram_image_diffs", diffs, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
